// File: rtl/regfile_writeback_pkg.sv
// Shared widths, write-back select codes, load funct3 encodings and the
// pipeline slot record used by the register-file write-back block.
package regfile_writeback_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef struct packed {
    logic                  vld;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       dat;
  } wb_slot_t;

endpackage

// File: rtl/regfile_writeback_load_formatter.sv
// Combinational load extract/extend: picks a byte or halfword of the aligned
// load word by byte offset and sign/zero-extends it according to funct3.
module regfile_writeback_load_formatter
  import regfile_writeback_pkg::*;
(
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lsb,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lsb)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  // Odd offsets on halfwords trap upstream; only bit 1 selects the half.
  assign w_half = i_addr_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      F3_LW:   o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file writer: formats MEM/WB results, presents the address ADDR_LEAD
// cycles ahead of regWrite/writeData, and tracks/forwards pending writes.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int ADDR_LEAD = 2,
  parameter int MAX_PEND  = 3
)
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [1:0]            wb_sel,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic [XLEN-1:0]       pc_plus4,
  input  logic [2:0]            load_funct3,
  input  logic [1:0]            addr_lsb,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeRegister,
  output logic [XLEN-1:0]       writeData,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [XLEN-1:0]       fwd1_data,
  output logic [XLEN-1:0]       fwd2_data,
  output logic                  stall,
  output logic                  sb_error
);

  localparam int         DEPTH    = ADDR_LEAD + 1;
  localparam int         LAST     = DEPTH - 1;
  localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);

  logic [XLEN-1:0]       w_load_data;
  logic [XLEN-1:0]       w_wb_value;
  wb_slot_t              r_pipe [DEPTH];
  logic [REG_ADDR_W-1:0] r_wreg;
  logic [1:0]            r_count [NUM_REGS];
  logic                  r_sb_error;

  logic                  w_commit;
  logic [REG_ADDR_W-1:0] w_commit_rd;
  logic                  w_issue_fire;
  logic [NUM_REGS-1:0]   w_inc;
  logic [NUM_REGS-1:0]   w_dec;

  regfile_writeback_load_formatter u_load_formatter (
    .i_rdata    (mem_rdata),
    .i_funct3   (load_funct3),
    .i_addr_lsb (addr_lsb),
    .o_data     (w_load_data)
  );

  always_comb begin
    w_wb_value = alu_result;
    case (wb_sel)
      WB_LOAD: w_wb_value = w_load_data;
      WB_PC4:  w_wb_value = pc_plus4;
      WB_ALU:  w_wb_value = alu_result;
      default: w_wb_value = alu_result;
    endcase
  end

  // Slot 0 is the youngest; slot LAST is the commit slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      r_wreg <= '0;
    end else begin
      r_pipe[0] <= '{vld: wb_valid, rd: wb_rd, dat: w_wb_value};
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      if (wb_valid) r_wreg <= wb_rd;
    end
  end

  assign w_commit      = r_pipe[LAST].vld && (r_pipe[LAST].rd != '0);
  assign w_commit_rd   = r_pipe[LAST].rd;
  assign regWrite      = w_commit;
  assign writeData     = w_commit ? r_pipe[LAST].dat : '0;
  assign writeRegister = r_wreg;

  assign issue_ready  = (r_count[issue_rd] != PEND_MAX);
  assign w_issue_fire = issue_valid && issue_ready && (issue_rd != '0);
  assign w_inc = w_issue_fire ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << issue_rd) : '0;
  assign w_dec = w_commit     ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << w_commit_rd) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) r_count[r] <= '0;
      r_sb_error <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_inc[r] && !w_dec[r])
          r_count[r] <= r_count[r] + 2'd1;
        else if (w_dec[r] && !w_inc[r] && (r_count[r] != 2'd0))
          r_count[r] <= r_count[r] - 2'd1;
      end
      // A same-cycle issue to the retiring register covers the retire.
      if (w_commit && !w_inc[w_commit_rd] && (r_count[w_commit_rd] == 2'd0))
        r_sb_error <= 1'b1;
    end
  end

  assign sb_error = r_sb_error;

  // Scan oldest to youngest so the youngest match overrides.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = LAST; i >= 0; i--) begin
      if (r_pipe[i].vld && (r_pipe[i].rd == rs1) && (rs1 != '0)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = r_pipe[i].dat;
      end
      if (r_pipe[i].vld && (r_pipe[i].rd == rs2) && (rs2 != '0)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = r_pipe[i].dat;
      end
    end
  end

  assign stall = ((r_count[rs1] != 2'd0) && !fwd1_hit) ||
                 ((r_count[rs2] != 2'd0) && !fwd2_hit);

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: table-driven load/select formatting
// plus hand-written sequences for timing, forwarding, scoreboard and reset.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic [31:0] alu_result, mem_rdata, pc_plus4;
  logic [2:0]  load_funct3;
  logic [1:0]  addr_lsb;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [4:0]  rs1, rs2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic        stall, sb_error;

  int n_pass  = 0;
  int n_total = 0;

  regfile_writeback dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4),
    .load_funct3(load_funct3), .addr_lsb(addr_lsb),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .stall(stall), .sb_error(sb_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] val);
    wb_valid = 1'b1; wb_rd = rd; wb_sel = WB_ALU; alu_result = val;
  endtask

  logic seen_wr, seen_hit;

  initial begin
    vecs[0]  = '{WB_LOAD, F3_LB,  2'd3, 32'h80F07F81, 32'h0, 32'h0, 32'hFFFFFF80};
    vecs[1]  = '{WB_LOAD, F3_LBU, 2'd3, 32'h80F07F81, 32'h0, 32'h0, 32'h00000080};
    vecs[2]  = '{WB_LOAD, F3_LH,  2'd2, 32'h80F07F81, 32'h0, 32'h0, 32'hFFFF80F0};
    vecs[3]  = '{WB_LOAD, F3_LHU, 2'd0, 32'h80F07F81, 32'h0, 32'h0, 32'h00007F81};
    vecs[4]  = '{WB_LOAD, F3_LW,  2'd0, 32'h80F07F81, 32'h0, 32'h0, 32'h80F07F81};
    vecs[5]  = '{WB_LOAD, F3_LB,  2'd0, 32'h80F07F81, 32'h0, 32'h0, 32'hFFFFFF81};
    vecs[6]  = '{WB_LOAD, F3_LBU, 2'd1, 32'h80F07F81, 32'h0, 32'h0, 32'h0000007F};
    vecs[7]  = '{WB_LOAD, F3_LH,  2'd1, 32'h80F07F81, 32'h0, 32'h0, 32'h00007F81};
    vecs[8]  = '{WB_LOAD, F3_LHU, 2'd3, 32'h80F07F81, 32'h0, 32'h0, 32'h000080F0};
    vecs[9]  = '{WB_LOAD, 3'd3,   2'd1, 32'h80F07F81, 32'h0, 32'h0, 32'h80F07F81};
    vecs[10] = '{WB_PC4,  F3_LB,  2'd0, 32'h80F07F81, 32'h5, 32'h00400004, 32'h00400004};
    vecs[11] = '{2'd3,    F3_LB,  2'd0, 32'h80F07F81, 32'hDEADBEEF, 32'h9, 32'hDEADBEEF};
    vecs[12] = '{WB_ALU,  F3_LB,  2'd0, 32'h80F07F81, 32'h11111111, 32'h9, 32'h11111111};

    reset = 1'b1; issue_valid = 1'b0; issue_rd = '0; wb_valid = 1'b0; wb_rd = '0;
    wb_sel = WB_ALU; alu_result = '0; mem_rdata = '0; pc_plus4 = '0;
    load_funct3 = F3_LW; addr_lsb = '0; rs1 = '0; rs2 = '0;
    tick; tick;
    reset = 1'b0;
    #2;
    chk("rst_regWrite", regWrite, 0);
    chk("rst_writeRegister", writeRegister, 0);
    chk("rst_writeData", writeData, 0);
    chk("rst_fwd_hits", {fwd1_hit, fwd2_hit}, 0);
    chk("rst_stall", stall, 0);
    chk("rst_sb_error", sb_error, 0);
    chk("rst_issue_ready", issue_ready, 1);

    // ALU result timing: address at t+1, data strobe only at t+3
    issue_valid = 1'b1; issue_rd = 5; tick; issue_valid = 1'b0;
    wb(5, 32'h12345678); #2; chk("alu_t_regWrite", regWrite, 0); tick;
    wb_valid = 1'b0; #2;
    chk("alu_t1_writeRegister", writeRegister, 5);
    chk("alu_t1_regWrite", regWrite, 0); tick;
    #2; chk("alu_t2_regWrite", regWrite, 0); tick;
    #2;
    chk("alu_t3_regWrite", regWrite, 1);
    chk("alu_t3_writeData", writeData, 32'h12345678);
    tick;
    #2;
    chk("alu_t4_regWrite", regWrite, 0);
    chk("alu_t4_sb_error", sb_error, 0);

    // Formatting table, back-to-back write-backs to x10..x22
    for (int i = 0; i < NV; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(10 + i); tick;
    end
    issue_valid = 1'b0;
    for (int c = 0; c < NV + 3; c++) begin
      if (c < NV) begin
        wb_valid = 1'b1; wb_rd = 5'(10 + c); wb_sel = vecs[c].sel;
        load_funct3 = vecs[c].f3; addr_lsb = vecs[c].lsb; mem_rdata = vecs[c].rdata;
        alu_result = vecs[c].alu; pc_plus4 = vecs[c].pc4;
      end else begin
        wb_valid = 1'b0;
      end
      #2;
      if (c >= 3) begin
        chk($sformatf("vec%0d_regWrite", c - 3), regWrite, 1);
        chk($sformatf("vec%0d_writeData", c - 3), writeData, vecs[c-3].exp);
      end
      tick;
    end
    rs1 = 10; rs2 = 22; #2;
    chk("vec_counts_drained_stall", stall, 0);
    chk("vec_sb_error", sb_error, 0);

    // Forwarding: newest of two in-flight x7 values wins
    issue_valid = 1'b1; issue_rd = 7; tick; tick; issue_valid = 1'b0;
    rs1 = 7; rs2 = 7; #2;
    chk("fwd_pending_stall", stall, 1);
    chk("fwd_pending_hit", fwd1_hit, 0);
    wb(7, 32'hA); tick;
    wb(7, 32'hB); #2;
    chk("fwd_t1_data", fwd1_data, 32'hA); tick;
    wb_valid = 1'b0; #2;
    chk("fwd_t2_hit", {fwd1_hit, fwd2_hit}, 2'b11);
    chk("fwd_t2_data1", fwd1_data, 32'hB);
    chk("fwd_t2_data2", fwd2_data, 32'hB);
    chk("fwd_t2_stall", stall, 0);
    tick; #2;
    chk("fwd_t3_writeData", writeData, 32'hA);
    chk("fwd_t3_data", fwd1_data, 32'hB);
    tick; #2;
    chk("fwd_t4_writeData", writeData, 32'hB);
    chk("fwd_t4_commit_slot_hit", {fwd1_hit, fwd1_data}, {1'b1, 32'hB});
    tick; #2;
    chk("fwd_t5_hit", fwd1_hit, 0);
    chk("fwd_t5_stall", stall, 0);
    chk("fwd_t5_sb_error", sb_error, 0);

    // Scoreboard saturation on x9
    rs1 = 0; rs2 = 0;
    issue_valid = 1'b1; issue_rd = 9; tick; tick; tick;
    #2; chk("sat_ready_full", issue_ready, 0); tick;
    issue_valid = 1'b0; rs1 = 9; #2;
    chk("sat_ready_after_4th", issue_ready, 0);
    chk("sat_stall", stall, 1);
    wb(9, 32'h9); tick; tick; tick;
    wb_valid = 1'b0; tick; tick; tick;
    #2;
    chk("sat_drained_ready", issue_ready, 1);
    chk("sat_drained_stall", stall, 0);
    chk("sat_sb_error", sb_error, 0);

    // Issue and commit to x12 in the same cycle leaves the count at 1
    rs1 = 0;
    issue_valid = 1'b1; issue_rd = 12; tick; issue_valid = 1'b0;
    wb(12, 32'hC); tick; wb_valid = 1'b0; tick; tick;
    issue_valid = 1'b1; issue_rd = 12; #2;
    chk("same_cycle_regWrite", regWrite, 1); tick;
    issue_valid = 1'b0; rs1 = 12; #2;
    chk("same_cycle_stall", stall, 1);
    chk("same_cycle_sb_error", sb_error, 0);

    // rd = 0 never writes and never forwards
    rs1 = 0; rs2 = 0;
    wb(0, 32'h55); tick; wb_valid = 1'b0;
    seen_wr = 1'b0; seen_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2; seen_wr |= regWrite; seen_hit |= fwd1_hit | fwd2_hit; tick;
    end
    chk("x0_no_regWrite", seen_wr, 0);
    chk("x0_no_fwd", seen_hit, 0);
    chk("x0_sb_error", sb_error, 0);

    // Retire x3 with nothing pending: sticky error
    wb(3, 32'h33); tick; wb_valid = 1'b0; tick; tick;
    #2;
    chk("err_commit", regWrite, 1);
    chk("err_not_yet", sb_error, 0); tick;
    #2; chk("err_set", sb_error, 1); tick; tick;
    rs1 = 3; #2;
    chk("err_sticky", sb_error, 1);
    chk("err_count_stays_zero", stall, 0);

    // Reset while x4 is in flight
    rs1 = 0;
    wb(4, 32'h44); tick; wb_valid = 1'b0; reset = 1'b1; #2;
    chk("rstmid_writeRegister_t1", writeRegister, 4); tick;
    reset = 1'b0; rs1 = 4; rs2 = 12; issue_rd = 12; #2;
    chk("rstmid_regWrite", regWrite, 0);
    chk("rstmid_writeRegister", writeRegister, 0);
    chk("rstmid_writeData", writeData, 0);
    chk("rstmid_sb_error", sb_error, 0);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_fwd", {fwd1_hit, fwd2_hit}, 0);
    chk("rstmid_ready", issue_ready, 1);
    seen_wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick; #2; seen_wr |= regWrite;
    end
    chk("rstmid_no_commit", seen_wr, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
